platform_button_pio: RTL and testbench

//  Avalon-MM slave input port. It pairs with the platform output PIOs.
//  - Samples WIDTH asynchronous board inputs (push-buttons/switches) and synchronises them.
//  - Debounces each bit and detects edges, latching them in a write-1-to-clear register.
//  - Raises a level IRQ to the Nios II when a captured edge is unmasked.
//  - Sits on the platform interconnect alongside the hex/LED output ports.

---
 rtl/platform_button_pio_pkg.sv | 31 +++
 rtl/platform_button_pio_if.sv | 18 +
 rtl/platform_debounce_bit.sv | 51 +++++
 rtl/platform_button_pio.sv | 91 +++++++++
 tb/tb_platform_button_pio.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/platform_button_pio_pkg.sv
// Shared constants for the platform PIO blocks: register word addresses and
// edge-type encodings (also used by the output PIOs).
package platform_button_pio_pkg;

    // Register word addresses
    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
    localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

    // Edge-type encodings for the EDGE_TYPE parameter
    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

    // Per-bit event selection for a given edge type
    function automatic logic edge_event(input int unsigned edge_type,
                                        input logic deb, input logic deb_prev);
        logic ev;
        ev = 1'b0;
        if (edge_type == EDGE_RISE) begin
            ev = deb & ~deb_prev;
        end else if (edge_type == EDGE_FALL) begin
            ev = ~deb & deb_prev;
        end else begin
            ev = deb ^ deb_prev;
        end
        return ev;
    endfunction

endpackage

// File: rtl/platform_button_pio_if.sv
// Avalon-MM slave bus bundle for the platform PIO register ports.
interface platform_button_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/platform_debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a stability counter. The
// debounced level only follows the synchronised input after DEBOUNCE_CYCLES
// consecutive cycles of disagreement; any return to the old level restarts.
module platform_debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic        RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic deb
);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            deb_q, deb_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Synchroniser, counter and debounced level registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q  <= RESET_VAL;
            s2_q  <= RESET_VAL;
            deb_q <= RESET_VAL;
            cnt_q <= '0;
        end else begin
            s1_q  <= in_bit;
            s2_q  <= s1_q;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Count disagreement cycles; accept the new level on the last one
    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign deb = deb_q;

endmodule

// File: rtl/platform_button_pio.sv
// Debounced push-button/switch input PIO with edge capture (write-1-to-clear),
// interrupt mask and a registered level IRQ.
module platform_button_pio
    import platform_button_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    platform_button_pio_if.slave bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] event_q, event_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic             irq_q;
    logic             wr_en;
    logic [WIDTH-1:0] w1c;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        platform_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_LEVEL[i])
        ) u_deb (
            .clk     (clk),
            .reset_n (reset_n),
            .in_bit  (in_port[i]),
            .deb     (deb[i])
        );
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata;

    // Edge select, mask write and W1C with a same-cycle event taking priority
    always_comb begin
        event_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            event_d[i] = edge_event(EDGE_TYPE, deb[i], deb_prev_q[i]);
        end
        mask_d = mask_q;
        w1c    = '0;
        if (wr_en && bus.address == PIO_ADDR_MASK) begin
            mask_d = bus.writedata[WIDTH-1:0];
        end
        if (wr_en && bus.address == PIO_ADDR_EDGE) begin
            w1c = bus.writedata[WIDTH-1:0];
        end
        edge_d = (edge_q & ~w1c) | event_q;
    end

    // Edge pipeline, register file and interrupt registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= RESET_LEVEL;
            event_q    <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            event_q    <= event_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            irq_q      <= |(edge_q & mask_q);
        end
    end

    // Zero-wait-state read mux; drives 0 when not reading
    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect && bus.write_n) begin
            case (bus.address)
                PIO_ADDR_DATA: bus.readdata = 32'(deb);
                PIO_ADDR_MASK: bus.readdata = 32'(mask_q);
                PIO_ADDR_EDGE: bus.readdata = 32'(edge_q);
                default:       bus.readdata = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_platform_button_pio.sv
// Directed bench: two instances (falling-edge and any-edge) share inputs and bus.
module tb_platform_button_pio;
    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic        irq0, irq1;

    int checks = 0;
    int errors = 0;

    platform_button_pio_if bus0 ();
    platform_button_pio_if bus1 ();

    assign bus0.address    = address;
    assign bus0.chipselect = chipselect;
    assign bus0.write_n    = write_n;
    assign bus0.writedata  = writedata;
    assign bus1.address    = address;
    assign bus1.chipselect = chipselect;
    assign bus1.write_n    = write_n;
    assign bus1.writedata  = writedata;

    platform_button_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .RESET_LEVEL     (4'hF)
    ) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in_port),
        .irq     (irq0)
    );

    platform_button_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (2),
        .RESET_LEVEL     (4'hF)
    ) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .in_port (in_port),
        .irq     (irq1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Combinational read of both instances, called between clock edges
    task automatic rd(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d1);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d0 = bus0.readdata;
        d1 = bus1.readdata;
        chipselect = 1'b0;
    endtask

    // Called at a negedge; the write lands on the following posedge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    logic [31:0] r0, r1;

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        rd(2'd0, r0, r1); check("rst_data", r0, 32'hF);
        rd(2'd2, r0, r1); check("rst_mask", r0, 32'h0);
        rd(2'd3, r0, r1); check("rst_edge", r0, 32'h0);
        check("rst_irq", {31'b0, irq0}, 32'h0);

        // Clean press of bit0: capture lands exactly 8 edges after the change
        @(negedge clk);
        in_port = 4'hE;
        repeat (7) @(negedge clk);
        rd(2'd3, r0, r1); check("press_edge_early", r0, 32'h0);
        @(negedge clk);
        rd(2'd3, r0, r1); check("press_edge", r0, 32'h1);
        rd(2'd0, r0, r1); check("press_data", r0, 32'hE);
        @(negedge clk);
        check("press_irq_masked", {31'b0, irq0}, 32'h0);

        // Data is read-only, reserved reads 0
        wr(2'd0, 32'h0);
        rd(2'd0, r0, r1); check("data_ro", r0, 32'hE);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, r0, r1); check("rsvd_zero", r0, 32'h0);

        wr(2'd3, 32'hF);
        rd(2'd3, r0, r1); check("clear_all", r0, 32'h0);

        // Bounce on bit1: 3-cycle runs never reach the 4-cycle threshold
        for (int k = 0; k < 10; k++) begin
            in_port[1] = k[0];
            repeat (3) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        rd(2'd0, r0, r1); check("bounce_data", r0, 32'hE);
        rd(2'd3, r0, r1); check("bounce_edge", r0, 32'h0);

        // Release of bit0: ignored by falling-edge instance, seen by any-edge one
        in_port[0] = 1'b1;
        repeat (12) @(negedge clk);
        rd(2'd0, r0, r1); check("release_data", r0, 32'hF);
        rd(2'd3, r0, r1);
        check("release_fall_edge", r0, 32'h0);
        check("release_any_edge", r1, 32'h1);
        wr(2'd3, 32'hF);

        // IRQ and W1C
        wr(2'd2, 32'h1);
        rd(2'd2, r0, r1); check("mask_rw", r0, 32'h1);
        in_port[0] = 1'b0;
        repeat (8) @(negedge clk);
        rd(2'd3, r0, r1); check("irq_edge", r0, 32'h1);
        check("irq_lag", {31'b0, irq0}, 32'h0);
        @(negedge clk);
        check("irq_set", {31'b0, irq0}, 32'h1);
        wr(2'd3, 32'h0);
        rd(2'd3, r0, r1); check("w1c_zero_edge", r0, 32'h1);
        check("w1c_zero_irq", {31'b0, irq0}, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, r0, r1); check("w1c_edge", r0, 32'h0);
        @(negedge clk);
        check("w1c_irq", {31'b0, irq0}, 32'h0);

        // Collision: W1C of bit2 on the same edge its falling event is captured
        in_port[2] = 1'b0;
        repeat (7) @(negedge clk);
        wr(2'd3, 32'h5);
        rd(2'd3, r0, r1); check("collision_edge", r0, 32'h4);
        @(negedge clk);
        check("collision_irq_unmasked", {31'b0, irq0}, 32'h0);

        // Mid-run reset during a pending bit3 debounce
        in_port[3] = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        in_port = 4'hF;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd0, r0, r1); check("mid_rst_data", r0, 32'hF);
        rd(2'd2, r0, r1); check("mid_rst_mask", r0, 32'h0);
        rd(2'd3, r0, r1); check("mid_rst_edge", r0, 32'h0);
        check("mid_rst_irq", {31'b0, irq0}, 32'h0);
        repeat (12) @(negedge clk);
        rd(2'd3, r0, r1);
        check("post_rst_edge_fall", r0, 32'h0);
        check("post_rst_edge_any", r1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
